// File: rtl/gbe_ctr_snapshot_ctrl.sv
// gbe_ctr_snapshot_ctrl: OPB slave that copies a bank of GbE counters into a shadow bank on command.
// Build option GBE_CTR_AUTO_CLR_EN: also clear the counters after every completed snapshot.
//
// state     | meaning
// S_IDLE    | waiting for a SNAP command
// S_CAPTURE | copying counter r_idx into its shadow, one per clock
// S_DONE    | bump seq, issue any pending clear
module gbe_ctr_snapshot_ctrl #(
    parameter logic [31:0] C_BASEADDR = 32'h01088100,
    parameter logic [31:0] C_HIGHADDR = 32'h010881FF,
    parameter int          C_NUM_CTR  = 4
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst_n,
    input  logic [0:31]              OPB_ABus,
    input  logic [0:3]               OPB_BE,
    input  logic [0:31]              OPB_DBus,
    input  logic                     OPB_RNW,
    input  logic                     OPB_select,
    input  logic                     OPB_seqAddr,
    output logic [0:31]              Sl_DBus,
    output logic                     Sl_xferAck,
    output logic                     Sl_retry,
    output logic                     Sl_errAck,
    output logic                     Sl_toutSup,
    input  logic [C_NUM_CTR*32-1:0]  ctr_in,
    output logic                     ctr_clr
);

`ifdef GBE_CTR_AUTO_CLR_EN
    localparam logic AUTO_CLR = 1'b1;
`else
    localparam logic AUTO_CLR = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [15:0] r_seq;
    logic        r_overrun;
    logic        r_clr_pend;
    logic        r_ctr_clr;
    logic [31:0] r_shadow [C_NUM_CTR];
    logic        r_xfer_ack;
    logic        r_retry;
    logic        r_cmd_snap;
    logic        r_cmd_clr;
    logic        r_stat_rd;
    logic [31:0] r_rdata;

    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_off;
    logic [29:0] w_word;
    logic        w_in_win;
    logic        w_req;
    logic        w_busy;
    logic        w_shadow_hit;
    logic [31:0] w_shadow_data;
    logic        w_retry;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_unused_ok;

    // Bit 0 of the OPB buses is the MSB, so a plain assignment keeps numeric value.
    assign w_addr   = OPB_ABus;
    assign w_wdata  = OPB_DBus;
    assign w_off    = w_addr - C_BASEADDR;
    assign w_word   = w_off[31:2];
    assign w_in_win = (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
    assign w_busy   = (r_state != S_IDLE);
    assign w_req    = OPB_select && w_in_win && !r_xfer_ack && !r_retry;

    always_comb begin
        w_shadow_hit  = 1'b0;
        w_shadow_data = '0;
        for (int k = 0; k < C_NUM_CTR; k++) begin
            if (w_word == 30'(k + 2)) begin
                w_shadow_hit  = 1'b1;
                w_shadow_data = r_shadow[k];
            end
        end
    end

    assign w_retry = w_req && OPB_RNW && w_shadow_hit && w_busy;
    assign w_ack   = w_req && !w_retry;

    always_comb begin
        w_rdata = '0;
        if (w_word == 30'd1)
            w_rdata = {w_busy, r_overrun, 14'd0, r_seq};
        else if (w_shadow_hit)
            w_rdata = w_shadow_data;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_xfer_ack <= 1'b0;
            r_retry    <= 1'b0;
            r_rdata    <= '0;
            r_cmd_snap <= 1'b0;
            r_cmd_clr  <= 1'b0;
            r_stat_rd  <= 1'b0;
        end else begin
            r_xfer_ack <= w_ack;
            r_retry    <= w_retry;
            r_rdata    <= (w_ack && OPB_RNW) ? w_rdata : '0;
            r_cmd_snap <= w_ack && !OPB_RNW && (w_word == 30'd0) && w_wdata[0];
            r_cmd_clr  <= w_ack && !OPB_RNW && (w_word == 30'd0) && w_wdata[1];
            r_stat_rd  <= w_ack && OPB_RNW && (w_word == 30'd1);
        end
    end

    // Commands act in their ack cycle; capture starts the cycle after.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_seq      <= '0;
            r_overrun  <= 1'b0;
            r_clr_pend <= 1'b0;
            r_ctr_clr  <= 1'b0;
            for (int k = 0; k < C_NUM_CTR; k++)
                r_shadow[k] <= '0;
        end else begin
            r_ctr_clr <= 1'b0;
            if (r_cmd_snap && w_busy)
                r_overrun <= 1'b1;
            else if (r_stat_rd)
                r_overrun <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_cmd_snap) begin
                        r_state    <= S_CAPTURE;
                        r_idx      <= '0;
                        r_clr_pend <= r_cmd_clr;
                    end else if (r_cmd_clr) begin
                        r_ctr_clr <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    for (int k = 0; k < C_NUM_CTR; k++) begin
                        if (r_idx == 6'(k))
                            r_shadow[k] <= ctr_in[32*k +: 32];
                    end
                    if (r_cmd_clr)
                        r_clr_pend <= 1'b1;
                    if (r_idx == 6'(C_NUM_CTR - 1)) begin
                        r_state    <= S_DONE;
                        r_ctr_clr  <= r_clr_pend | r_cmd_clr | AUTO_CLR;
                        r_clr_pend <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                S_DONE: begin
                    r_seq   <= r_seq + 16'd1;
                    r_state <= S_IDLE;
                    // The DONE pulse is already committed; a clear arriving now goes out next cycle.
                    if (r_cmd_clr)
                        r_ctr_clr <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Sl_DBus     = r_rdata;
    assign Sl_xferAck  = r_xfer_ack;
    assign Sl_retry    = r_retry;
    assign Sl_errAck   = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign ctr_clr     = r_ctr_clr;
    assign w_unused_ok = ^{OPB_BE, OPB_seqAddr, w_wdata[31:2], w_off[1:0]};

endmodule

// File: tb/tb_gbe_ctr_snapshot_ctrl.sv
// Testbench for gbe_ctr_snapshot_ctrl: vector table for idle register access plus
// hand-written sequences for capture timing, retry, overrun, clears, seq wrap and reset.
module tb_gbe_ctr_snapshot_ctrl;
    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h01088100;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [0:31]     abus = '0;
    logic [0:3]      be = 4'hF;
    logic [0:31]     dbus_w = '0;
    logic            rnw = 1'b0;
    logic            sel = 1'b0;
    logic            seqa = 1'b0;
    logic [0:31]     sl_dbus;
    logic            ack;
    logic            retry;
    logic            errack;
    logic            tout;
    logic [N*32-1:0] ctr_in;
    logic            ctr_clr;

    int          g = 0;
    logic [31:0] ctr_val = '0;
    bit          ramp = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          clr_cnt = 0;
    int          clr_last = -1;
    logic [15:0] eseq = '0;

    gbe_ctr_snapshot_ctrl dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus_w), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqa),
        .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_retry(retry), .Sl_errAck(errack),
        .Sl_toutSup(tout), .ctr_in(ctr_in), .ctr_clr(ctr_clr)
    );

    always #5 clk = ~clk;

    // g is the index of the most recent rising edge.
    always @(posedge clk) g++;

    always @(negedge clk) begin
        if (ramp) ctr_val = 32'(g);
        if (ctr_clr) begin
            clr_cnt++;
            clr_last = g;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++)
            ctr_in[32*k +: 32] = 32'(k + 1) * 32'h11111111 + ctr_val;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One transfer: select for one cycle, sample the response cycle. n_ack = edge starting it.
    task automatic bus(input logic r, input logic [31:0] addr, input logic [31:0] wd,
                       output logic a, output logic rt, output logic [31:0] d, output int n_ack);
        @(posedge clk); #1;
        sel = 1'b1; rnw = r; abus = addr; dbus_w = wd;
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b0; abus = '0; dbus_w = '0;
        a = ack; rt = retry; d = sl_dbus; n_ack = g;
    endtask

    task automatic rd(input string name, input int word, input logic [31:0] exp);
        logic a, rt; logic [31:0] d; int n;
        bus(1'b1, BASE + 32'(word * 4), '0, a, rt, d, n);
        check({name, ".ack"}, 32'(a), 32'd1);
        check({name, ".data"}, d, exp);
    endtask

    task automatic wr(input string name, input int word, input logic [31:0] wd, output int n);
        logic a, rt; logic [31:0] d;
        bus(1'b0, BASE + 32'(word * 4), wd, a, rt, d, n);
        check({name, ".ack"}, 32'(a), 32'd1);
    endtask

    typedef struct {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        eack;
        logic        eretry;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n2, c0, acks;
        logic a, rt; logic [31:0] d; int n;
        logic [3:0] pat;

        // Idle accesses after one snapshot of constant counters {4,3,2,1}x0x11111111, seq = 1.
        tbl[0]  = '{1'b1, BASE + 32'h00, 32'h0,        1'b1, 1'b0, 32'h00000000};
        tbl[1]  = '{1'b1, BASE + 32'h04, 32'h0,        1'b1, 1'b0, 32'h00000001};
        tbl[2]  = '{1'b1, BASE + 32'h08, 32'h0,        1'b1, 1'b0, 32'h11111111};
        tbl[3]  = '{1'b1, BASE + 32'h0C, 32'h0,        1'b1, 1'b0, 32'h22222222};
        tbl[4]  = '{1'b1, BASE + 32'h10, 32'h0,        1'b1, 1'b0, 32'h33333333};
        tbl[5]  = '{1'b1, BASE + 32'h14, 32'h0,        1'b1, 1'b0, 32'h44444444};
        tbl[6]  = '{1'b1, BASE + 32'h18, 32'h0,        1'b1, 1'b0, 32'h00000000};
        tbl[7]  = '{1'b1, BASE + 32'hFC, 32'h0,        1'b1, 1'b0, 32'h00000000};
        tbl[8]  = '{1'b0, BASE + 32'h04, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000};
        tbl[9]  = '{1'b0, BASE + 32'h08, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
        tbl[10] = '{1'b0, BASE - 32'h04, 32'h00000001, 1'b0, 1'b0, 32'h00000000};
        tbl[11] = '{1'b1, 32'h01088200, 32'h0,         1'b0, 1'b0, 32'h00000000};
        tbl[12] = '{1'b1, BASE + 32'h04, 32'h0,        1'b1, 1'b0, 32'h00000001};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.dbus", sl_dbus, 32'h0);
        check("rst.flags", {27'd0, ack, retry, errack, tout, ctr_clr}, 32'h0);
        rst_n = 1'b1;
        rd("rst.status", 1, 32'h00000000);

        // Constant-counter snapshot, then the vector table
        wr("snap0", 0, 32'h1, n2);
        repeat (5) @(posedge clk);
        eseq = 16'd1;
        for (int i = 0; i < 13; i++) begin
            bus(tbl[i].rnw, tbl[i].addr, tbl[i].wd, a, rt, d, n);
            check($sformatf("vec%0d.ack", i), 32'(a), 32'(tbl[i].eack));
            check($sformatf("vec%0d.retry", i), 32'(rt), 32'(tbl[i].eretry));
            check($sformatf("vec%0d.data", i), d, tbl[i].edata);
        end

        // Ramping counters: counter k sampled k cycles after the first capture cycle
        ramp = 1'b1;
        wr("snap1", 0, 32'h1, n2);
        rd("snap1.busy", 1, {16'h8000, eseq});
        repeat (5) @(posedge clk);
        eseq++;
        rd("snap1.status", 1, {16'h0000, eseq});
        for (int k = 0; k < N; k++)
            rd($sformatf("snap1.shadow%0d", k), k + 2,
               32'(k + 1) * 32'h11111111 + 32'(n2 + 1 + k));

        // Shadow read while busy is retried, then acked once idle
        wr("snap2", 0, 32'h1, n2);
        bus(1'b1, BASE + 32'h08, '0, a, rt, d, n);
        check("retry.ack", 32'(a), 32'd0);
        check("retry.retry", 32'(rt), 32'd1);
        check("retry.data", d, 32'h0);
        repeat (5) @(posedge clk);
        eseq++;
        rd("retry.again", 2, 32'h11111111 + 32'(n2 + 1));
        ramp = 1'b0;

        // SNAP while busy sets overrun; STATUS read clears it
        wr("ovr.snap", 0, 32'h1, n2);
        wr("ovr.snap2", 0, 32'h1, n2);
        rd("ovr.status", 1, {16'hC000, eseq});
        repeat (5) @(posedge clk);
        eseq++;
        rd("ovr.cleared", 1, {16'h0000, eseq});

        // SNAP+CLR: one pulse in DONE
        c0 = clr_cnt;
        wr("clr3", 0, 32'h3, n2);
        repeat (8) @(posedge clk);
        eseq++;
        check("clr3.count", 32'(clr_cnt - c0), 32'd1);
        check("clr3.when", 32'(clr_last), 32'(n2 + 5));

        // CLR alone in IDLE: pulse one cycle after ack, no snapshot
        c0 = clr_cnt;
        wr("clr2", 0, 32'h2, n2);
        repeat (3) @(posedge clk);
        check("clr2.count", 32'(clr_cnt - c0), 32'd1);
        check("clr2.when", 32'(clr_last), 32'(n2 + 1));
        rd("clr2.status", 1, {16'h0000, eseq});

        // CLR during capture is deferred to DONE
        c0 = clr_cnt;
        wr("clrb.snap", 0, 32'h1, n2);
        wr("clrb.clr", 0, 32'h2, n);
        repeat (8) @(posedge clk);
        eseq++;
        check("clrb.count", 32'(clr_cnt - c0), 32'd1);
        check("clrb.when", 32'(clr_last), 32'(n2 + 5));

        // SNAP alone: pulses at DONE only with auto-clear built in
        c0 = clr_cnt;
        wr("auto.snap", 0, 32'h1, n2);
        repeat (8) @(posedge clk);
        eseq++;
`ifdef GBE_CTR_AUTO_CLR_EN
        check("auto.count", 32'(clr_cnt - c0), 32'd1);
        check("auto.when", 32'(clr_last), 32'(n2 + 5));
`else
        check("auto.count", 32'(clr_cnt - c0), 32'd0);
`endif

        // Held select: responses no closer than every other cycle
        @(posedge clk); #1;
        sel = 1'b1; rnw = 1'b1; abus = BASE + 32'h04;
        acks = 0;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pat[3 - i] = ack;
            if (ack) acks++;
        end
        sel = 1'b0; rnw = 1'b0; abus = '0;
        check("held.acks", 32'(acks), 32'd2);
        check("held.pattern", 32'(pat), 32'hA);

        // Sequence wrap
        force dut.r_seq = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_seq;
        rd("wrap.pre", 1, 32'h0000FFFF);
        wr("wrap.snap", 0, 32'h1, n2);
        repeat (5) @(posedge clk);
        rd("wrap.post", 1, 32'h00000000);

        // Reset mid-capture: capture aborted, no clear
        c0 = clr_cnt;
        wr("rstcap.snap", 0, 32'h3, n2);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rstcap.dbus", sl_dbus, 32'h0);
        check("rstcap.flags", {29'd0, ack, retry, ctr_clr}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        check("rstcap.noclr", 32'(clr_cnt - c0), 32'd0);
        rd("rstcap.status", 1, 32'h00000000);
        for (int k = 0; k < N; k++)
            rd($sformatf("rstcap.shadow%0d", k), k + 2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gbe_ctr_snapshot_ctrl.md
# gbe_ctr_snapshot_ctrl

OPB slave that sequences coherent snapshots of a bank of GbE core counters (rx/tx packet, error and overrun counts) for software. On a command written over OPB it copies one counter per clock into a shadow bank, publishes a sequence number and busy/overrun status, and issues counter-clear pulses. It sits on the OPB bus beside the per-counter software registers and replaces ad-hoc per-register polling with a single snapshot-then-read protocol.

## Interface
- C_BASEADDR, 32'h01088100, first byte of the slave window
- C_HIGHADDR, 32'h010881FF, last byte of the slave window
- C_NUM_CTR, 4, number of counters, legal 1..62
- OPB_Clk  in  1  sole clock; counters and bus are synchronous to it
- OPB_Rst_n  in  1  asynchronous, active-low reset
- OPB_ABus  in  [0:31]  address, bit 0 MSB
- OPB_BE  in  [0:3]  byte enables; ignored, all accesses are full-word
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data, zero except in the ack cycle
- Sl_xferAck  out  1  one-cycle transfer acknowledge
- Sl_retry  out  1  one-cycle retry
- Sl_errAck  out  1  tied 0
- Sl_toutSup  out  1  tied 0
- ctr_in  in  C_NUM_CTR*32  flat counter vector; counter k = bits [32k+31:32k]
- ctr_clr  out  1  one-cycle pulse clearing all upstream counters

## Operation
- Word index w = (OPB_ABus - C_BASEADDR) >> 2. Word bit i drives Sl_DBus[31-i].
- w=0 CONTROL (write): bit0 SNAP request, bit1 CLR request. Reads return 0.
- w=1 STATUS (read): bit31 busy, bit30 overrun (sticky), bits15:0 seq. Reading STATUS clears overrun in the ack cycle. Writes are acked and ignored.
- w=2..C_NUM_CTR+1: shadow k=w-2, read-only; writes are acked and ignored. w beyond C_NUM_CTR+1 but inside the window reads 0.
- FSM IDLE -> CAPTURE -> DONE -> IDLE.
  - IDLE: SNAP write -> CAPTURE with idx=0.
  - CAPTURE: shadow[idx] <= ctr_in[idx]; idx++; after idx=C_NUM_CTR-1 -> DONE.
  - DONE: seq <= seq+1, wrapping 0xFFFF -> 0x0000; pending clear is issued (see below); -> IDLE.
- busy = state != IDLE.
- SNAP write while busy: ignored; overrun <= 1. If the same cycle also clears overrun, set wins.
- CLR write in IDLE without SNAP: ctr_clr pulses the cycle after the ack.
- CLR with SNAP, or CLR while busy: clear is held pending and pulses in the DONE cycle, after the last copy. A clear is never issued mid-capture.
- A read of shadow words while busy gets Sl_retry, not Sl_xferAck, and Sl_DBus stays 0. STATUS and CONTROL reads are always acked.

## Timing
- Reset: FSM IDLE, idx 0, seq 0, overrun 0, shadows 0. All outputs 0, including Sl_DBus, Sl_xferAck, Sl_retry and ctr_clr. Reset mid-capture aborts the capture; no ctr_clr is emitted.
- Decode: OPB_select high with address in the window at cycle t -> Sl_xferAck or Sl_retry high at t+1 only. Read data is registered and valid at t+1.
- Back-to-back: no new response in the cycle after any response. With select held, responses come at most every 2 cycles.
- SNAP acked at t: CAPTURE during t+1..t+C_NUM_CTR, with counter k sampled at t+1+k. DONE at t+C_NUM_CTR+1. busy is high for C_NUM_CTR+1 cycles, and IDLE is visible at t+C_NUM_CTR+2.
- Counters are copied sequentially, so per-counter skew is k cycles. Software treats the snapshot as coherent to within C_NUM_CTR cycles.

## Configuration
- GBE_CTR_AUTO_CLR_EN defined: every completed snapshot also pulses ctr_clr in DONE, giving read-and-clear semantics. It merges with any pending CLR into a single pulse.
- GBE_CTR_AUTO_CLR_EN undefined: ctr_clr pulses only on explicit CLR requests.

## Test plan
- Reset with ctr_in = {4, 3, 2, 1}×0x11111111 -> all outputs 0; STATUS read returns 0x00000000.
- Write CONTROL=0x1 at t -> busy read 0x80000000 during capture; after t+6, STATUS=0x00000001 and shadow k reads ctr_in[k] as sampled at t+1+k (ramping counter input gives distinct offsets).
- Read shadow word 2 while busy -> Sl_retry for 1 cycle, no xferAck, Sl_DBus=0. Retrying after DONE is acked with data.
- SNAP during busy -> STATUS=0xC0000000. A second STATUS read shows bit30 cleared.
- Write CONTROL=0x3 -> single ctr_clr pulse coinciding with DONE, not before. Write 0x2 in IDLE -> pulse exactly one cycle after ack. With GBE_CTR_AUTO_CLR_EN, 0x1 alone also pulses at DONE.
- Preload seq=0xFFFF via 65535 snapshots (or force) -> next snapshot wraps seq to 0x0000. Assert OPB_Rst_n low mid-CAPTURE -> shadows 0, no ctr_clr.
